// File: rtl/unary_gen_11.sv
// Unary bitstream generator: emits a FRAME_LEN-bit frame whose count of ones equals
// the captured value, with ones packed at the front (thermometer) or evenly spread.
module unary_gen_11 #(
    parameter int FRAME_LEN = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        load,
    input  logic [10:0] din,
    input  logic        mode,
    output logic        busy,
    output logic        dout,
    output logic        dout_valid,
    output logic        done,
    output logic        sat
);

    localparam int CW = 11;
    localparam logic [0:0]    IDLE   = 1'b0;
    localparam logic [0:0]    RUN    = 1'b1;
    localparam logic [CW-1:0] FL_W   = CW'(FRAME_LEN);
    localparam logic [CW-1:0] LAST_W = CW'(FRAME_LEN - 1);

    logic [0:0]    state_r, state_s;
    logic [CW-1:0] cnt_r, cnt_s;
    logic [CW-1:0] val_r, val_s;
    logic          mode_r, mode_s;
    logic          sat_r, sat_s;
    logic          dout_r, dout_s;
    logic          dout_valid_r, dout_valid_s;
    logic          done_r, done_s;
    logic [9:0]    pos_s;
    logic          bit_s;

    function automatic logic [9:0] bit_rev10(input logic [9:0] x);
        logic [9:0] r;
        for (int i = 0; i < 10; i++) begin
            r[i] = x[9-i];
        end
        return r;
    endfunction

    // Spread mode visits positions in bit-reversed order so ones are evenly interleaved.
    always_comb begin
        if (mode_r) begin
            pos_s = bit_rev10(cnt_r[9:0]);
        end else begin
            pos_s = cnt_r[9:0];
        end
        bit_s = ({1'b0, pos_s} < val_r);
    end

    // Next-state logic; the done cycle stays in RUN so busy drops one cycle after done.
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r;
        val_s        = val_r;
        mode_s       = mode_r;
        sat_s        = sat_r;
        dout_s       = 1'b0;
        dout_valid_s = 1'b0;
        done_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (load) begin
                    val_s   = (din > FL_W) ? FL_W : din;
                    mode_s  = mode;
                    sat_s   = (din > FL_W);
                    cnt_s   = {CW{1'b0}};
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (done_r) begin
                    state_s = IDLE;
                end else if (en) begin
                    dout_s       = bit_s;
                    dout_valid_s = 1'b1;
                    cnt_s        = cnt_r + 11'd1;
                    done_s       = (cnt_r == LAST_W);
                end else begin
                    cnt_s = cnt_r;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            cnt_r        <= {CW{1'b0}};
            val_r        <= {CW{1'b0}};
            mode_r       <= 1'b0;
            sat_r        <= 1'b0;
            dout_r       <= 1'b0;
            dout_valid_r <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            cnt_r        <= cnt_s;
            val_r        <= val_s;
            mode_r       <= mode_s;
            sat_r        <= sat_s;
            dout_r       <= dout_s;
            dout_valid_r <= dout_valid_s;
            done_r       <= done_s;
        end
    end

    assign busy       = (state_r == RUN);
    assign dout       = dout_r;
    assign dout_valid = dout_valid_r;
    assign done       = done_r;
    assign sat        = sat_r;

endmodule

// File: tb/tb_unary_gen_11.sv
// Directed bench for unary_gen_11: whole frames in both placement modes, saturation,
// en gating, ignored loads, and asynchronous reset mid-frame.
module tb_unary_gen_11;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        load;
    logic [10:0] din;
    logic        mode;
    logic        busy;
    logic        dout;
    logic        dout_valid;
    logic        done;
    logic        sat;

    int nvec = 0;
    int nerr = 0;

    unary_gen_11 #(.FRAME_LEN(1024)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .load       (load),
        .din        (din),
        .mode       (mode),
        .busy       (busy),
        .dout       (dout),
        .dout_valid (dout_valid),
        .done       (done),
        .sat        (sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic start(input string tag, input logic [10:0] d, input logic m, input logic exp_sat);
        load = 1'b1;
        din  = d;
        mode = m;
        tick();
        load = 1'b0;
        chk({tag, " busy_after_load"}, busy, 1'b1);
        chk({tag, " no_valid_at_load"}, dout_valid, 1'b0);
        chk({tag, " sat"}, sat, exp_sat);
    endtask

    // ptype 0: bit i is (i < v); ptype 1: bit i is 1 for even i; ptype 2: count only
    task automatic run_frame(input string tag, input int exp_ones, input int ptype, input int v,
                             input bit toggle, input bit pulse_load, input int exp_cycles,
                             input logic exp_sat);
        int   nvalid = 0;
        int   nones = 0;
        int   bad = 0;
        int   ndone = 0;
        int   cyc = 0;
        logic busy_at_done = 1'b0;
        logic expb;
        bit   fin = 1'b0;
        while (!fin && cyc < 6000) begin
            en = toggle ? ((cyc % 2) == 0) : 1'b1;
            if (pulse_load && cyc == 100) begin
                load = 1'b1;
                din  = 11'd5;
                mode = 1'b0;
            end else begin
                load = 1'b0;
            end
            tick();
            cyc++;
            if (dout_valid === 1'b1) begin
                expb = (ptype == 0) ? (nvalid < v) : ((nvalid % 2) == 0);
                if (ptype != 2 && dout !== expb) bad++;
                if (dout === 1'b1) nones++;
                if (!en) bad++;
                nvalid++;
            end else if (dout !== 1'b0) begin
                bad++;
            end
            if (done === 1'b1) begin
                ndone++;
                busy_at_done = busy;
                fin = 1'b1;
                if (dout_valid !== 1'b1) bad++;
            end
        end
        chk({tag, " valid_bits"}, nvalid, 1024);
        chk({tag, " ones"}, nones, exp_ones);
        chk({tag, " bit_errors"}, bad, 0);
        chk({tag, " done_pulses"}, ndone, 1);
        chk({tag, " busy_at_done"}, busy_at_done, 1'b1);
        if (exp_cycles > 0) chk({tag, " cycles_to_done"}, cyc, exp_cycles);
        // a load presented alongside done must be ignored
        load = 1'b1;
        din  = 11'd5;
        mode = 1'b0;
        en   = 1'b1;
        tick();
        load = 1'b0;
        chk({tag, " busy_after_done"}, busy, 1'b0);
        chk({tag, " done_one_cycle"}, done, 1'b0);
        chk({tag, " idle_valid"}, dout_valid, 1'b0);
        chk({tag, " sat_hold"}, sat, exp_sat);
    endtask

    initial begin
        int   nv;
        int   cyc;
        logic seen_done;

        rst_n = 1'b0;
        en    = 1'b1;
        load  = 1'b0;
        din   = 11'd0;
        mode  = 1'b0;
        repeat (3) tick();
        chk("reset busy", busy, 1'b0);
        chk("reset dout", dout, 1'b0);
        chk("reset dout_valid", dout_valid, 1'b0);
        chk("reset done", done, 1'b0);
        chk("reset sat", sat, 1'b0);
        rst_n = 1'b1;

        start("zero", 11'd0, 1'b0, 1'b0);
        run_frame("zero", 0, 0, 0, 1'b0, 1'b0, 1024, 1'b0);

        start("therm300", 11'd300, 1'b0, 1'b0);
        run_frame("therm300", 300, 0, 300, 1'b0, 1'b0, 1024, 1'b0);

        start("spread512", 11'd512, 1'b1, 1'b0);
        run_frame("spread512", 512, 1, 512, 1'b0, 1'b0, 1024, 1'b0);

        start("sat2047", 11'd2047, 1'b0, 1'b1);
        run_frame("sat2047", 1024, 0, 1024, 1'b0, 1'b0, 1024, 1'b1);

        start("full1024", 11'd1024, 1'b0, 1'b0);
        run_frame("full1024", 1024, 0, 1024, 1'b0, 1'b0, 1024, 1'b0);

        start("spread700", 11'd700, 1'b1, 1'b0);
        run_frame("spread700", 700, 2, 700, 1'b1, 1'b1, 2047, 1'b0);

        // reset mid-frame after 500 bits
        start("rst", 11'd2000, 1'b0, 1'b1);
        nv = 0;
        cyc = 0;
        seen_done = 1'b0;
        en = 1'b1;
        while (nv < 500 && cyc < 2000) begin
            tick();
            cyc++;
            if (dout_valid === 1'b1) nv++;
            if (done === 1'b1) seen_done = 1'b1;
        end
        chk("rst bits_before", nv, 500);
        chk("rst dout_before", dout, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst async busy", busy, 1'b0);
        chk("rst async dout", dout, 1'b0);
        chk("rst async dout_valid", dout_valid, 1'b0);
        chk("rst async sat", sat, 1'b0);
        tick();
        if (done === 1'b1) seen_done = 1'b1;
        chk("rst no_done", seen_done, 1'b0);
        chk("rst held busy", busy, 1'b0);
        #2;
        rst_n = 1'b1;
        start("after_rst", 11'd10, 1'b0, 1'b0);
        run_frame("after_rst", 10, 0, 10, 1'b0, 1'b0, 1024, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
